// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_PRESENT = 1'b1
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       extended;
    logic       brk;
  } ps2_event_t;

endpackage

// File: rtl/ps2_scan_ctrl.sv
// Pops PS/2 FIFO bytes, folds E0/F0 prefixes into one event, presents it over valid/ack.
// Optional macro PS2_SCAN_TIMEOUT_EN drops a dangling prefix after TIMEOUT_CYCLES idle cycles.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         rx_byte_valid,
  input  logic                         fifo_not_empty,
  input  logic                         fifo_full,
  input  logic [$clog2(FIFO_SIZE)-1:0] fifo_count,
  input  logic [7:0]                   fifo_top_data_out,
  output logic                         fifo_read,
  output logic                         event_valid,
  output logic [7:0]                   event_code,
  output logic                         event_extended,
  output logic                         event_break,
  input  logic                         event_ack,
  output logic                         overflow,
  input  logic                         overflow_clr,
  output logic                         irq,
  output ps2_state_e                   dbg_state
);

  // Handshake: event_valid stays high with stable event fields until the cycle
  // event_ack is sampled high; ack while no event is pending has no effect.

  ps2_state_e r_state;
  ps2_state_e w_next_state;
  ps2_event_t r_evt;
  logic       r_ext;
  logic       r_brk;
  logic       r_event_valid;
  logic       r_overflow;
  logic       w_pop;
  logic       w_is_ext;
  logic       w_is_brk;
  logic       w_ovf_set;
  logic       w_timeout;
  logic       w_unused;

  assign w_pop     = (r_state == S_FETCH) & fifo_not_empty & reset_n;
  assign w_is_ext  = (fifo_top_data_out == PS2_EXT_PREFIX);
  assign w_is_brk  = (fifo_top_data_out == PS2_BREAK_PREFIX);
  assign w_ovf_set = rx_byte_valid & fifo_full & ~w_pop;

`ifdef PS2_SCAN_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;
  logic          w_waiting;

  assign w_waiting = (r_state == S_FETCH) & (r_ext | r_brk) & ~fifo_not_empty;
  // Firing on the last count keeps the prefix alive for exactly TIMEOUT_CYCLES idle cycles.
  assign w_timeout = w_waiting & (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_unused  = ^fifo_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (!w_waiting || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + CW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_unused  = ^fifo_count ^ (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    fifo_read    = 1'b0;
    case (r_state)
      S_FETCH: begin
        fifo_read = w_pop;
        if (w_pop && !w_is_ext && !w_is_brk) begin
          w_next_state = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (event_ack) begin
          w_next_state = S_FETCH;
        end
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext         <= 1'b0;
      r_brk         <= 1'b0;
      r_evt         <= '0;
      r_event_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_pop) begin
        if (w_is_ext) begin
          r_ext <= 1'b1;
        end else if (w_is_brk) begin
          r_brk <= 1'b1;
        end else begin
          r_evt.code     <= fifo_top_data_out;
          r_evt.extended <= r_ext;
          r_evt.brk      <= r_brk;
          r_ext          <= 1'b0;
          r_brk          <= 1'b0;
          r_event_valid  <= 1'b1;
        end
      end else if (w_timeout) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
      if (r_state == S_PRESENT && event_ack) begin
        r_event_valid <= 1'b0;
      end
      // A lost byte in the same cycle as a clear must stay visible.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign event_valid    = r_event_valid;
  assign event_code     = r_evt.code;
  assign event_extended = r_evt.extended;
  assign event_break    = r_evt.brk;
  assign overflow       = r_overflow;
  assign irq            = r_event_valid | r_overflow;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench for ps2_scan_ctrl: behavioural FIFO, directed byte sequences, event scoreboard.
module tb_ps2_scan_ctrl;
  import ps2_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       rx_byte_valid;
  logic       fifo_not_empty;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic [7:0] fifo_top_data_out;
  logic       fifo_read;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_extended;
  logic       event_break;
  logic       event_ack;
  logic       overflow;
  logic       overflow_clr;
  logic       irq;
  ps2_state_e dbg_state;

  ps2_scan_ctrl #(.FIFO_SIZE(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .rx_byte_valid(rx_byte_valid),
    .fifo_not_empty(fifo_not_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .fifo_top_data_out(fifo_top_data_out), .fifo_read(fifo_read),
    .event_valid(event_valid), .event_code(event_code),
    .event_extended(event_extended), .event_break(event_break),
    .event_ack(event_ack), .overflow(overflow), .overflow_clr(overflow_clr),
    .irq(irq), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int ack_cyc = 0;
  int pop_cyc_q[$];
  logic [7:0] fifo_q[$];
  logic [9:0] exp_q[$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic fifo_refresh();
    fifo_not_empty    = (fifo_q.size() != 0);
    fifo_top_data_out = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    fifo_count        = 3'(fifo_q.size());
  endtask

  // behavioural FIFO: pop when the DUT strobed fifo_read at this edge
  always @(posedge clk) begin
    logic did_pop;
    did_pop = fifo_read;
    #1;
    if (did_pop && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
      pop_cyc_q.push_back(cyc);
      fifo_refresh();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_refresh();
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back({code, ext, brk});
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!event_valid && n < budget) begin
      tick();
      n++;
    end
    if (!event_valid) begin
      total++;
      bad++;
      $display("FAIL %s: event_valid not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic do_ack();
    event_ack = 1'b1;
    tick();
    event_ack = 1'b0;
    ack_cyc = cyc;
  endtask

  // scoreboard monitor
  logic       prev_v = 1'b0;
  logic [9:0] held;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (event_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL event_unexpected: got 0x%0h with no expected event", {event_code, event_extended, event_break});
        end else begin
          check("event_fields", {event_code, event_extended, event_break}, exp_q.pop_front());
        end
        held = {event_code, event_extended, event_break};
      end else if (event_valid && prev_v) begin
        if ({event_code, event_extended, event_break} !== held) begin
          check("event_stable", {event_code, event_extended, event_break}, held);
        end
      end
      prev_v = event_valid;
    end
  end

  initial begin
    int pops_before;
    logic saw_pop;
    reset_n = 1'b0; rx_byte_valid = 1'b0; fifo_full = 1'b0;
    event_ack = 1'b0; overflow_clr = 1'b0;
    fifo_refresh();
    repeat (3) @(posedge clk);
    check("rst_event_valid", event_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_overflow", overflow, 0);
    #2 reset_n = 1'b1;
    repeat (3) tick();
    check("idle_state", dbg_state, S_FETCH);
    check("idle_no_pop", fifo_read, 0);
    check("idle_pop_cnt", pop_cnt, 0);

    // single byte
    push_byte(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0);
    wait_valid("single", 10);
    check("single_pop_cnt", pop_cnt, 1);
    check("single_irq", irq, 1);
    repeat (5) tick();
    check("single_held", event_valid, 1);
    check("single_no_pop", pop_cnt, 1);
    do_ack();
    check("single_ack_valid", event_valid, 0);
    check("single_ack_irq", irq, 0);

    // full prefix sequence
    pop_cyc_q.delete();
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h74);
    expect_evt(8'h74, 1'b1, 1'b1);
    wait_valid("e0f074", 10);
    check("seq_pops", pop_cyc_q.size(), 3);
    if (pop_cyc_q.size() == 3) check("seq_back_to_back", pop_cyc_q[2] - pop_cyc_q[0], 2);
    do_ack();

    // backpressure
    push_byte(8'h5A); expect_evt(8'h5A, 1'b0, 1'b0);
    wait_valid("bp_first", 10);
    push_byte(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0);
    pops_before = pop_cnt;
    saw_pop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (fifo_read) saw_pop = 1'b1;
      tick();
    end
    check("bp_no_read", saw_pop, 0);
    check("bp_pop_cnt", pop_cnt, pops_before);
    do_ack();
    tick();
    check("bp_pop_after_ack", pop_cnt, pops_before + 1);
    check("bp_pop_cycle", pop_cyc_q[$], ack_cyc + 1);
    check("bp_new_event", event_valid, 1);

    // overflow while event pending
    fifo_full = 1'b1; rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_irq", irq, 1);
    rx_byte_valid = 1'b1; overflow_clr = 1'b1;
    tick();
    rx_byte_valid = 1'b0; overflow_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0; fifo_full = 1'b0;
    check("ovf_clr", overflow, 0);
    check("ovf_irq_event", irq, 1);
    do_ack();
    check("ovf_irq_idle", irq, 0);

    // held break prefix on empty FIFO, stray ack ignored
    push_byte(8'hF0);
    repeat (5) tick();
    check("hold_state", dbg_state, S_FETCH);
    do_ack();
    check("stray_ack_valid", event_valid, 0);
    push_byte(8'h00); expect_evt(8'h00, 1'b0, 1'b1);
    wait_valid("hold_f0_00", 10);
    do_ack();

    // repeated prefixes and reversed order
    push_byte(8'hE0); push_byte(8'hE0); push_byte(8'hFF);
    expect_evt(8'hFF, 1'b1, 1'b0);
    wait_valid("e0e0ff", 10);
    do_ack();
    push_byte(8'hF0); push_byte(8'hE0); push_byte(8'hE1);
    expect_evt(8'hE1, 1'b1, 1'b1);
    wait_valid("f0e0e1", 10);
    do_ack();

    // dangling E0 across an idle gap
    push_byte(8'hE0);
    repeat (18) tick();
`ifdef PS2_SCAN_TIMEOUT_EN
    push_byte(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0);
`else
    push_byte(8'h1C); expect_evt(8'h1C, 1'b1, 1'b0);
`endif
    wait_valid("timeout", 10);
    do_ack();

    // asynchronous reset mid-event
    push_byte(8'h33); expect_evt(8'h33, 1'b0, 1'b0);
    wait_valid("pre_reset", 10);
    fifo_full = 1'b1; rx_byte_valid = 1'b1;
    tick();
    fifo_full = 1'b0; rx_byte_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("arst_valid", event_valid, 0);
    check("arst_fields", {event_code, event_extended, event_break}, 0);
    check("arst_overflow", overflow, 0);
    check("arst_irq", irq, 0);
    check("arst_read", fifo_read, 0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check("post_rst_state", dbg_state, S_FETCH);
    check("post_rst_no_pop", fifo_read, 0);
    push_byte(8'h44); expect_evt(8'h44, 1'b0, 1'b0);
    wait_valid("post_reset", 10);
    do_ack();

    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scan_ctrl.md
Name: ps2_scan_ctrl

Overview:
- Consumer-side sequencer for the PS/2 receive FIFO.
- Pops raw bytes from the FIFO read port and folds E0 (extended) and F0 (break) prefixes into one scan-code event.
- Presents the event to the 8051 SFR layer through a valid/ack handshake.
- Tracks FIFO overrun and drives the keyboard interrupt line.

Parameters:
- FIFO_SIZE, 8: depth of the attached FIFO; sets the fifo_count width to $clog2(FIFO_SIZE).
- TIMEOUT_CYCLES, 1000000: cycles a dangling prefix is held before it is discarded (optional feature only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- rx_byte_valid  in  1  PS/2 receiver byte strobe; same signal as the FIFO write strobe
- fifo_not_empty  in  1  FIFO status
- fifo_full  in  1  FIFO status
- fifo_count  in  $clog2(FIFO_SIZE)  FIFO occupancy; informational, only exported
- fifo_top_data_out  in  8  FIFO head byte, combinational, valid while fifo_not_empty
- fifo_read  out  1  pop strobe, one cycle per consumed byte
- event_valid  out  1  scan-code event pending
- event_code  out  8  final non-prefix byte
- event_extended  out  1  E0 prefix was seen
- event_break  out  1  F0 prefix was seen (key release)
- event_ack  in  1  SFR layer has taken the event
- overflow  out  1  sticky: a byte was lost to a full FIFO
- overflow_clr  in  1  clears overflow
- irq  out  1  interrupt level, equal to event_valid | overflow

Behaviour:
- Reset: all outputs 0; state S_FETCH; ext_flag = 0; brk_flag = 0; event registers 0.
- Reset mid-sequence discards any prefixes and any pending event. FIFO contents are not touched.
- FSM has two states: S_FETCH and S_PRESENT.
- fifo_read = (state == S_FETCH) & fifo_not_empty. It is combinational from registered state plus FIFO status.
- On each pop, the head byte is decoded in the same cycle:
  - 0xE0: ext_flag <= 1; stay in S_FETCH.
  - 0xF0: brk_flag <= 1; stay in S_FETCH.
  - Prefix order is free; repeated prefixes are idempotent.
  - Any other byte, including 0x00, 0xE1 and 0xFF: event_code <= byte; event_extended <= ext_flag; event_break <= brk_flag; clear both flags; event_valid <= 1; go to S_PRESENT.
- Throughput: one byte per cycle. event_valid rises the cycle after the final byte is popped.
- S_PRESENT:
  - fifo_read is held 0. The FIFO may fill meanwhile.
  - The event outputs are stable.
  - On event_ack: event_valid <= 0 and return to S_FETCH. The next pop happens no earlier than the following cycle.
  - event_ack in S_FETCH is ignored.
- Overflow: set when rx_byte_valid & fifo_full & ~fifo_read. Cleared by overflow_clr. If set and clear occur in the same cycle, set wins.
- irq is combinational: event_valid | overflow.
- Empty FIFO with prefixes held: stay in S_FETCH and keep the flags.

Optional Feature:
- Macro: PS2_SCAN_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments while in S_FETCH with (ext_flag | brk_flag) set and the FIFO empty.
  - The counter resets on any pop or when no flag is set.
  - When the count reaches TIMEOUT_CYCLES, both flags are cleared and the counter returns to 0.
- Undefined: the counter does not exist and prefixes are held indefinitely.

Decomposition:
- Package ps2_pkg holds:
  - PS2_EXT_PREFIX = 8'hE0 and PS2_BREAK_PREFIX = 8'hF0.
  - The state enum typedef (S_FETCH, S_PRESENT).
  - A packed struct type for the event (code, extended, break).
- Single module; no sub-module. The timeout counter is small enough to stay inline.

Test Plan:
- Reset: assert reset_n = 0 mid-event -> all outputs read 0 immediately (asynchronously); after release the bench sees state S_FETCH with no pop until fifo_not_empty.
- Single byte: FIFO head 0x1C -> fifo_read high for one cycle; next cycle event_valid = 1, code = 0x1C, ext = 0, brk = 0, irq = 1. Outputs held until event_ack, then event_valid = 0.
- Full prefix sequence: FIFO holds E0, F0, 74 -> fifo_read high for three consecutive cycles; then event code = 0x74, ext = 1, brk = 1.
- Backpressure: event pending, FIFO holds 0x1C, no ack for 100 cycles -> fifo_read stays 0. Ack at cycle 100 -> pop in cycle 101 and a new event in cycle 102.
- Overflow: fifo_full = 1 with rx_byte_valid pulsed while in S_PRESENT -> overflow = 1 and irq = 1. overflow_clr in the same cycle as a second lost byte -> overflow stays 1. Lone overflow_clr -> 0.
- Timeout, with PS2_SCAN_TIMEOUT_EN and TIMEOUT_CYCLES = 16: pop E0, FIFO empty for 16 cycles, then byte 0x1C -> event ext = 0. Same stimulus without the macro -> ext = 1.
